// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline-stage definitions: default widths, the NOP encoding and the
// packed stage-entry layout (MSB->LSB: valid, halt, pc, pc_plus2, instr).
package pipe_stage_skid_pkg;

  localparam int              DEF_PC_W     = 16;
  localparam int              DEF_INSTR_W  = 16;
  localparam logic [15:0]     DEF_NOP_INSTR = 16'h0800;

  function automatic int entry_w(input int pc_w, input int instr_w);
    return 2 + 2 * pc_w + instr_w;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_stage_slot.sv
// One stage-entry register with load enable; resets to an invalid NOP entry.
module stage_slot
  import pipe_stage_skid_pkg::*;
#(
  parameter int                 PC_W      = DEF_PC_W,
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
  localparam int                EW        = entry_w(PC_W, INSTR_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [EW-1:0] d,
  output logic [EW-1:0] q
);

  localparam logic [EW-1:0] RST_VAL = {{(EW-INSTR_W){1'b0}}, NOP_INSTR};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Fetch-to-decode stage register: valid/ready handshake with a registered
// in_ready, a 2-entry skid (main + skid slot), flush and halt lock.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                 PC_W       = DEF_PC_W,
  parameter int                 INSTR_W    = DEF_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = INSTR_W'(DEF_NOP_INSTR),
  parameter bit                 HALT_BLOCK = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [PC_W-1:0]    in_pc_plus2,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc_plus2,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_halt
);

  localparam int EW = entry_w(PC_W, INSTR_W);
  localparam int PB = EW - 3;          // top bit of pc field

  logic [EW-1:0] m_q, s_q, m_d, s_d, in_ent;
  logic          m_en, s_en, m_vld, s_vld, s_vld_n;
  logic          acc, take, halt_lock, lock_n;

  assign in_ent = {1'b1, in_halt, in_pc, in_pc_plus2, in_instr};
  assign m_vld  = m_q[EW-1];
  assign s_vld  = s_q[EW-1];
  assign acc    = in_valid & in_ready;
  assign take   = m_vld & out_ready;

  // Emptying a slot only drops its valid bit so out_pc stays deterministic.
  always_comb begin
    m_en    = 1'b0;
    s_en    = 1'b0;
    m_d     = m_q;
    s_d     = s_q;
    s_vld_n = s_vld;
    lock_n  = halt_lock;
    if (flush) begin
      m_en    = 1'b1;
      s_en    = 1'b1;
      m_d     = {1'b0, m_q[EW-2:0]};
      s_d     = {1'b0, s_q[EW-2:0]};
      s_vld_n = 1'b0;
      lock_n  = 1'b0;
    end else begin
      if (acc & in_halt) lock_n = 1'b1;
      if (take) begin
        m_en = 1'b1;
        if (s_vld) begin
          m_d     = s_q;
          s_en    = 1'b1;
          s_d     = acc ? in_ent : {1'b0, s_q[EW-2:0]};
          s_vld_n = acc;
        end else begin
          m_d = acc ? in_ent : {1'b0, m_q[EW-2:0]};
        end
      end else if (acc) begin
        if (!m_vld) begin
          m_en = 1'b1;
          m_d  = in_ent;
        end else begin
          s_en    = 1'b1;
          s_d     = in_ent;
          s_vld_n = 1'b1;
        end
      end
    end
  end

  stage_slot #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)) u_main (
    .clk(clk), .rst(rst), .en(m_en), .d(m_d), .q(m_q)
  );

  stage_slot #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)) u_skid (
    .clk(clk), .rst(rst), .en(s_en), .d(s_d), .q(s_q)
  );

  // in_ready is 0 while in reset and rises on the first edge afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_lock <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      halt_lock <= lock_n;
      in_ready  <= ~s_vld_n & ~(HALT_BLOCK & lock_n);
    end
  end

  assign out_valid    = m_vld;
  assign out_halt     = m_vld & m_q[EW-2];
  assign out_pc       = m_q[PB -: PC_W];
  assign out_pc_plus2 = m_q[PB-PC_W -: PC_W];
  assign out_instr    = m_vld ? m_q[INSTR_W-1:0] : NOP_INSTR;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: two instances (HALT_BLOCK=1 and 0) share
// the same stimulus; outputs are checked 1 ns after each rising edge.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_halt, out_ready;
  logic [15:0] in_pc, in_pc_plus2, in_instr;

  logic        in_ready, out_valid, out_halt;
  logic [15:0] out_pc, out_pc_plus2, out_instr;
  logic        in_ready0, out_valid0, out_halt0;
  logic [15:0] out_pc0, out_pc_plus20, out_instr0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.HALT_BLOCK(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_plus2(in_pc_plus2), .in_instr(in_instr), .in_halt(in_halt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_plus2(out_pc_plus2), .out_instr(out_instr), .out_halt(out_halt)
  );

  pipe_stage_skid #(.HALT_BLOCK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_pc(in_pc), .in_pc_plus2(in_pc_plus2), .in_instr(in_instr), .in_halt(in_halt),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_pc(out_pc0), .out_pc_plus2(out_pc_plus20), .out_instr(out_instr0), .out_halt(out_halt0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] instr_of(input logic [15:0] pc);
    return {pc[7:0], 8'hA5};
  endfunction

  task automatic drive(input logic v, input logic [15:0] pc, input logic h);
    in_valid    = v;
    in_pc       = pc;
    in_pc_plus2 = pc + 16'd2;
    in_instr    = instr_of(pc);
    in_halt     = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // An accept while the skid slot is occupied would overwrite a held entry.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) begin
      checks++;
      assert (!dut.s_vld) else begin
        errors++;
        $error("FAIL acc_with_skid_full observed=1 expected=0");
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 16'h0800);
    chk("rst_out_pc",    out_pc, 0);
    chk("rst_out_pc2",   out_pc_plus2, 0);
    chk("rst_out_halt",  out_halt, 0);
    #11 rst = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // Streaming, one entry per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(2 * i), 1'b0);
      tick();
      chk("strm_valid", out_valid, 1);
      chk("strm_pc",    out_pc, 2 * i);
      chk("strm_pc2",   out_pc_plus2, 2 * i + 2);
      chk("strm_instr", out_instr, instr_of(16'(2 * i)));
      chk("strm_ready", in_ready, 1);
    end
    drive(1'b0, 16'h0, 1'b0);
    tick();
    chk("strm_drain_valid", out_valid, 0);
    chk("strm_drain_instr", out_instr, 16'h0800);
    chk("strm_hold_pc",     out_pc, 16'h000E);

    // Backpressure into the skid slot
    drive(1'b1, 16'h10, 1'b0);
    tick();
    chk("bp_first_pc", out_pc, 16'h10);
    out_ready = 1'b0;
    drive(1'b1, 16'h12, 1'b0);
    tick();
    chk("bp_hold_pc",   out_pc, 16'h10);
    chk("bp_ready_low", in_ready, 0);
    drive(1'b1, 16'h14, 1'b0);
    tick();
    chk("bp_hold_pc2",   out_pc, 16'h10);
    chk("bp_ready_low2", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_skid_pc", out_pc, 16'h12);
    chk("bp_ready_up", in_ready, 1);
    tick();
    chk("bp_last_pc",    out_pc, 16'h14);
    chk("bp_last_valid", out_valid, 1);
    drive(1'b0, 16'h0, 1'b0);
    tick();
    chk("bp_drained", out_valid, 0);

    // Flush with both slots full while upstream offers an entry
    out_ready = 1'b0;
    drive(1'b1, 16'h30, 1'b0);
    tick();
    drive(1'b1, 16'h32, 1'b0);
    tick();
    chk("fl_full_ready", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 16'h34, 1'b0);
    tick();
    chk("fl_valid", out_valid, 0);
    chk("fl_instr", out_instr, 16'h0800);
    chk("fl_halt",  out_halt, 0);
    chk("fl_ready", in_ready, 1);
    flush = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    tick();
    chk("fl_stay_empty", out_valid, 0);

    // Flush in the same cycle as an accept: the accepted entry is discarded
    drive(1'b1, 16'h40, 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, 16'h42, 1'b0);
    tick();
    chk("fla_valid", out_valid, 0);
    chk("fla_ready", in_ready, 1);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 16'h0, 1'b0);
    tick();
    chk("fla_no_ghost", out_valid, 0);

    // Halt: blocking instance locks, non-blocking instance keeps streaming
    out_ready = 1'b0;
    drive(1'b1, 16'h20, 1'b1);
    tick();
    chk("h1_out_halt", out_halt, 1);
    chk("h1_out_pc",   out_pc, 16'h20);
    chk("h1_ready",    in_ready, 0);
    chk("h0_ready",    in_ready0, 1);
    chk("h0_out_halt", out_halt0, 1);
    out_ready = 1'b1;
    drive(1'b1, 16'h22, 1'b0);
    tick();
    chk("h1_drained",   out_valid, 0);
    chk("h1_halt_mask", out_halt, 0);
    chk("h1_ready_hold", in_ready, 0);
    chk("h0_pc_22",     out_pc0, 16'h22);
    chk("h0_valid",     out_valid0, 1);
    drive(1'b1, 16'h24, 1'b0);
    tick();
    chk("h1_blocked",    out_valid, 0);
    chk("h1_ready_hold2", in_ready, 0);
    chk("h0_pc_24",      out_pc0, 16'h24);
    chk("h0_ready2",     in_ready0, 1);
    flush = 1'b1;
    drive(1'b0, 16'h0, 1'b0);
    tick();
    chk("h1_unlock", in_ready, 1);
    flush = 1'b0;
    drive(1'b1, 16'h50, 1'b0);
    tick();
    chk("h1_resume_pc", out_pc, 16'h50);
    chk("h1_resume_valid", out_valid, 1);

    // Asynchronous reset mid-cycle with the main slot full
    out_ready = 1'b0;
    drive(1'b1, 16'h60, 1'b0);
    tick();
    chk("ar_full", out_valid, 1);
    drive(1'b0, 16'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_instr", out_instr, 16'h0800);
    chk("ar_halt",  out_halt, 0);
    chk("ar_pc",    out_pc, 0);
    #3 rst = 1'b0;
    tick();
    chk("ar_ready", in_ready, 1);
    chk("ar_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
